div_unit: RTL and testbench

Multicycle signed 32-bit divider that serves the control unit's DIV request and sits next to the multiplier on the A/B register outputs. It accepts a one-cycle `start` from control and iterates one quotient bit per cycle using restoring division on magnitudes. It writes the quotient to `lo` and the remainder to `hi`, and returns a one-cycle `done` pulse. Divide-by-zero is reported on `div_zero` so control can raise the exception path.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_sign_fix.sv | 16 +
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and sizing for the multicycle divider.
//   div_state_e : FSM state encoding (IDLE, RUN, FIX, DONE)
//   DIV_DATA_W  : operand/result width, also the iteration count
//   DIV_CNT_W   : width of the iteration down-counter (holds 0..DIV_DATA_W)
package div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: combinational conditional two's-complement negate.
// Turns signed operands into magnitudes and restores the result signs.
//   val_i [W] : input value
//   neg_i     : 1 = output the two's complement of val_i, 0 = pass through
//   res_o [W] : result
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/div_unit.sv
// div_unit: multicycle signed divider, one quotient bit per cycle
// (restoring division on magnitudes). The quotient goes to lo and the
// remainder to hi; done pulses once per accepted start.
//
// Optional feature macro: DIV_UNSIGNED_EN adds the div_unsigned port (DIVU).
//
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous, active-high
//   start        : request, sampled only while busy = 0
//   dividend [W] : signed dividend (A register)
//   divisor  [W] : signed divisor (B register)
//   div_unsigned : (DIV_UNSIGNED_EN only) 1 = treat operands as unsigned
//   busy         : operation in progress
//   done         : one-cycle completion pulse
//   div_zero     : one-cycle pulse with done when the divisor was zero
//   hi       [W] : remainder (held between operations)
//   lo       [W] : quotient (held between operations)
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
  input  logic              div_unsigned,
`endif
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  div_state_e            state_q;
  logic [DIV_CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0]     rem_q, quo_q, dvs_q;
  logic                  qneg_q, rneg_q, zpend_q;
  logic                  busy_q, done_q, zero_q;
  logic [DATA_W-1:0]     hi_q, lo_q;

  logic                  uns;
  logic                  dvd_neg, dvs_neg;
  logic [DATA_W-1:0]     dvd_mag, dvs_mag;
  logic [DATA_W:0]       shift_w, trial_w;
  logic [DATA_W-1:0]     rem_d, quo_d;
  logic [DATA_W-1:0]     rem_fix, quo_fix;

`ifdef DIV_UNSIGNED_EN
  assign uns = div_unsigned;
`else
  assign uns = 1'b0;
`endif

  // In unsigned mode the raw operands are already the magnitudes.
  assign dvd_neg = dividend[DATA_W-1] & ~uns;
  assign dvs_neg = divisor[DATA_W-1]  & ~uns;

  div_sign_fix #(.W(DATA_W)) u_dvd_mag (.val_i(dividend), .neg_i(dvd_neg), .res_o(dvd_mag));
  div_sign_fix #(.W(DATA_W)) u_dvs_mag (.val_i(divisor),  .neg_i(dvs_neg), .res_o(dvs_mag));

  // One restoring step. The shifted partial remainder needs one extra bit
  // because it can reach 2*divisor-1; a negative trial keeps the shifted value.
  assign shift_w = {rem_q, quo_q[DATA_W-1]};
  assign trial_w = shift_w - {1'b0, dvs_q};
  assign rem_d   = trial_w[DATA_W] ? shift_w[DATA_W-1:0] : trial_w[DATA_W-1:0];
  assign quo_d   = {quo_q[DATA_W-2:0], ~trial_w[DATA_W]};

  div_sign_fix #(.W(DATA_W)) u_quo_fix (.val_i(quo_q), .neg_i(qneg_q), .res_o(quo_fix));
  div_sign_fix #(.W(DATA_W)) u_rem_fix (.val_i(rem_q), .neg_i(rneg_q), .res_o(rem_fix));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zpend_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      zero_q <= 1'b0;
      case (state_q)
        // DONE is not busy, so it accepts a new start exactly like IDLE.
        IDLE, DONE: begin
          if (start) begin
            rem_q   <= '0;
            quo_q   <= dvd_mag;
            dvs_q   <= dvs_mag;
            qneg_q  <= dvd_neg ^ dvs_neg;
            rneg_q  <= dvd_neg;
            cnt_q   <= DIV_CNT_W'(DATA_W);
            busy_q  <= 1'b1;
            zpend_q <= (divisor == '0);
            // Divide-by-zero passes through FIX for one cycle so done lands
            // one edge after start without writing hi/lo.
            state_q <= (divisor == '0) ? FIX : RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == DIV_CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          if (zpend_q) begin
            zero_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          zpend_q <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        uns;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_vec  = 0;
  int n_miss = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned (uns),
`endif
    .busy         (busy),
    .done         (done),
    .div_zero     (div_zero),
    .hi           (hi),
    .lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge. Start is sampled at the next edge (T);
  // operands are scrambled right after T to show they were captured.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 32'h1234_5678;
    divisor  = 32'h0;
    check_val({tag, " busy@T"}, {31'b0, busy}, 32'd1);
    check_val({tag, " done@T"}, {31'b0, done}, 32'd0);
    repeat (32) @(posedge clk);
    #1;
    check_val({tag, " busy@T+32"}, {31'b0, busy}, 32'd1);
    check_val({tag, " done@T+32"}, {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, " done@T+33"}, {31'b0, done}, 32'd1);
    check_val({tag, " busy@T+33"}, {31'b0, busy}, 32'd0);
    check_val({tag, " dz@T+33"}, {31'b0, div_zero}, 32'd0);
    check_val({tag, " lo"}, lo, exp_lo);
    check_val({tag, " hi"}, hi, exp_hi);
  endtask

  task automatic do_div0(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    dividend = a;
    divisor  = 32'h0;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    check_val({tag, " busy@T"}, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    check_val({tag, " done@T+1"}, {31'b0, done}, 32'd1);
    check_val({tag, " dz@T+1"}, {31'b0, div_zero}, 32'd1);
    check_val({tag, " busy@T+1"}, {31'b0, busy}, 32'd0);
    check_val({tag, " lo kept"}, lo, exp_lo);
    check_val({tag, " hi kept"}, hi, exp_hi);
    @(posedge clk); #1;
    check_val({tag, " done@T+2"}, {31'b0, done}, 32'd0);
    check_val({tag, " dz@T+2"}, {31'b0, div_zero}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    uns      = 1'b0;
    #1;
    check_val("rst busy", {31'b0, busy}, 32'd0);
    check_val("rst done", {31'b0, done}, 32'd0);
    check_val("rst dz",   {31'b0, div_zero}, 32'd0);
    check_val("rst hi",   hi, 32'd0);
    check_val("rst lo",   lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2);
    do_div0("5/0", 32'd5, 32'd14, 32'd2);
    @(posedge clk); #1;

    do_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    // Issued in the DONE cycle of the previous op: accepted back-to-back.
    do_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    do_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    do_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    do_div("min/2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0);
    do_div("max/1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0);
    do_div("5/100", 32'd5, 32'd100, 32'd0, 32'd5);
    do_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0);
    do_div("-1/2 signed", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
`ifdef DIV_UNSIGNED_EN
    uns = 1'b1;
    do_div("-1/2 divu", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
    do_div0("divu x/0", 32'd9, 32'h7FFF_FFFF, 32'd1);
    uns = 1'b0;
    @(posedge clk); #1;
    do_div("-1/2 div", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
`endif
    @(posedge clk); #1;

    // A second start while busy must not restart the operation.
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;               // T
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;               // T+5
    start = 1'b0;
    repeat (27) @(posedge clk);
    #1;                               // T+32
    check_val("ign done@T+32", {31'b0, done}, 32'd0);
    @(posedge clk); #1;               // T+33
    check_val("ign done@T+33", {31'b0, done}, 32'd1);
    check_val("ign lo", lo, 32'd14);
    check_val("ign hi", hi, 32'd2);
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;               // T
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;               // T+5
    start = 1'b0;
    check_val("mid busy@T+5", {31'b0, busy}, 32'd1);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid rst busy", {31'b0, busy}, 32'd0);
    check_val("mid rst done", {31'b0, done}, 32'd0);
    check_val("mid rst dz",   {31'b0, div_zero}, 32'd0);
    check_val("mid rst hi",   hi, 32'd0);
    check_val("mid rst lo",   lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check_val("mid no done", done_cnt, 32'd0);
    check_val("mid idle busy", {31'b0, busy}, 32'd0);
    do_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0);
    @(posedge clk); #1;
    check_val("9/3 done drop", {31'b0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
